// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: sequencer op codes, arbiter
// FSM states, owner IDs and bus widths.
package sdram_pkg;

    localparam int ADDR_W        = 22;
    localparam int DATA_W        = 16;
    localparam int LEN_W         = 8;
    localparam int PEND_W        = 4;
    localparam int HOST_MAX_WAIT = 2048;

    typedef enum logic [1:0] {
        OP_REFRESH    = 2'd0,
        OP_READ_BURST = 2'd1,
        OP_READ       = 2'd2,
        OP_WRITE      = 2'd3
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_REFRESH = 2'd1,
        OWN_VIDEO   = 2'd2,
        OWN_HOST    = 2'd3
    } owner_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh period counter plus saturating count of refreshes still owed.
// A period tick and a refresh completion in the same cycle cancel out.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int PERIOD = 780,
    parameter int URGENT = 4,
    parameter int MAX    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_dec,
    input  logic              clear,
    output logic [PEND_W-1:0] pending,
    output logic              urgent
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] period_cnt;
    logic             tick;

    assign tick   = (period_cnt == CNT_W'(PERIOD - 1));
    assign urgent = (pending >= PEND_W'(URGENT));

    // Free-running period counter, wraps to 0 on the tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (clear || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    // Pending refreshes: up on tick (saturating), down on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (clear) begin
            pending <= '0;
        end else if (tick && !tick_dec) begin
            if (pending != PEND_W'(MAX)) begin
                pending <= pending + PEND_W'(1);
            end
        end else if (tick_dec && !tick) begin
            if (pending != '0) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM between refresh, video prefetch and the host
// word port, issuing one operation at a time to the command sequencer.
// Optional build macro SDRAM_ARB_HOST_PROMOTE_EN: a host that has waited
// HOST_MAX_WAIT cycles is ranked above video (still below urgent refresh).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sequencer still initialising the SDRAM; nothing issued
// ST_IDLE | free; pick the next operation by priority
// ST_BUSY | one operation in flight, waiting for seq_done
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_URGENT = 4,
    parameter int REFRESH_MAX    = 8,
    parameter int VID_BURST      = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seq_ready,
    output logic              seq_start,
    output logic [1:0]        seq_op,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [LEN_W-1:0]  seq_len,
    output logic [DATA_W-1:0] seq_wdata,
    input  logic [DATA_W-1:0] seq_rdata,
    input  logic              seq_done,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              lock
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            sel;
    seq_op_t           op_q, op_d;
    logic              start_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  len_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rdata_d;
    logic              lock_d;
    logic [PEND_W-1:0] pending;
    logic              urgent;
    logic              refresh_done;
    logic              op_done;
    logic              host_promote;

    assign op_done      = (state_q == ST_BUSY) && seq_done;
    assign refresh_done = op_done && (owner_q == OWN_REFRESH);
    assign vid_ack      = op_done && (owner_q == OWN_VIDEO);
    assign host_ack     = op_done && (owner_q == OWN_HOST);
    assign seq_op       = op_q;

    sdram_refresh_timer #(
        .PERIOD (REFRESH_PERIOD),
        .URGENT (REFRESH_URGENT),
        .MAX    (REFRESH_MAX)
    ) u_refresh_timer (
        .clock    (clock),
        .reset    (reset),
        .tick_dec (refresh_done),
        .clear    (1'b0),
        .pending  (pending),
        .urgent   (urgent)
    );

`ifdef SDRAM_ARB_HOST_PROMOTE_EN
    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

    logic [WAIT_W-1:0] host_wait;

    assign host_promote = (host_wait == WAIT_W'(HOST_MAX_WAIT));

    // Host wait counter: runs while the host is kept waiting, clears on ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            host_wait <= '0;
        end else if (host_ack) begin
            host_wait <= '0;
        end else if (host_req && !host_promote) begin
            host_wait <= host_wait + WAIT_W'(1);
        end
    end
`else
    assign host_promote = 1'b0;
`endif

    // Priority pick among waiting requesters.
    always_comb begin
        sel = OWN_NONE;
        if (urgent) begin
            sel = OWN_REFRESH;
        end else if (host_promote && host_req) begin
            sel = OWN_HOST;
        end else if (vid_req) begin
            sel = OWN_VIDEO;
        end else if (pending != '0) begin
            sel = OWN_REFRESH;
        end else if (host_req) begin
            sel = OWN_HOST;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        start_d = 1'b0;
        op_d    = op_q;
        addr_d  = seq_addr;
        len_d   = seq_len;
        wdata_d = seq_wdata;
        rdata_d = host_rdata;
        case (state_q)
            ST_INIT: begin
                owner_d = OWN_NONE;
                if (seq_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sel != OWN_NONE) begin
                    state_d = ST_BUSY;
                    owner_d = sel;
                    start_d = 1'b1;
                    case (sel)
                        OWN_REFRESH: begin
                            op_d   = OP_REFRESH;
                            addr_d = '0;
                            len_d  = '0;
                        end
                        OWN_VIDEO: begin
                            op_d   = OP_READ_BURST;
                            addr_d = vid_addr;
                            len_d  = LEN_W'(VID_BURST);
                        end
                        default: begin
                            op_d    = host_we ? OP_WRITE : OP_READ;
                            addr_d  = host_addr;
                            len_d   = LEN_W'(1);
                            wdata_d = host_wdata;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (seq_done) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_HOST && op_q == OP_READ) begin
                        rdata_d = seq_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                owner_d = OWN_NONE;
            end
        endcase
        lock_d = (state_d == ST_INIT) ||
                 ((state_d == ST_BUSY) && (owner_d != OWN_HOST));
    end

    // State, owner and registered sequencer/host outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            owner_q    <= OWN_NONE;
            seq_start  <= 1'b0;
            op_q       <= OP_REFRESH;
            seq_addr   <= '0;
            seq_len    <= '0;
            seq_wdata  <= '0;
            host_rdata <= '0;
            lock       <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            seq_start  <= start_d;
            op_q       <= op_d;
            seq_addr   <= addr_d;
            seq_len    <= len_d;
            seq_wdata  <= wdata_d;
            host_rdata <= rdata_d;
            lock       <= lock_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int P   = 780;
    localparam int URG = 4;
    localparam int PMX = 8;
    localparam int VB  = 128;
    localparam int HMW = 2048;

    logic        clock, reset, seq_ready, seq_start, seq_done;
    logic [1:0]  seq_op;
    logic [21:0] seq_addr, vid_addr, host_addr;
    logic [7:0]  seq_len;
    logic [15:0] seq_wdata, seq_rdata, host_wdata, host_rdata;
    logic        vid_req, vid_ack, host_req, host_we, host_ack, lock;

    sdram_arbiter dut (
        .clock(clock), .reset(reset), .seq_ready(seq_ready),
        .seq_start(seq_start), .seq_op(seq_op), .seq_addr(seq_addr),
        .seq_len(seq_len), .seq_wdata(seq_wdata), .seq_rdata(seq_rdata),
        .seq_done(seq_done), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .lock(lock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: owner 0=none 1=refresh 2=video 3=host
    int          e;
    int          m_pend, m_own, m_wait;
    bit          m_ready, m_we;
    logic [15:0] m_rdata;
    int          done_cnt, cur_lat, host_grants;
    bit          spur_en, vid_oneshot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_start", 32'(seq_start), 32'd0);
        check("rst_lock", 32'(lock), 32'd1);
        check("rst_op", 32'(seq_op), 32'd0);
        check("rst_addr", 32'(seq_addr), 32'd0);
        check("rst_len", 32'(seq_len), 32'd0);
        check("rst_wdata", 32'(seq_wdata), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        seq_ready = 0; seq_done = 0; seq_rdata = 0; vid_req = 0; vid_addr = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        e = 0; m_pend = 0; m_own = 0; m_wait = 0; m_ready = 0; m_we = 0;
        m_rdata = 0; done_cnt = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock: predict from the spec rules, clock, compare, play sequencer.
    task automatic step();
        bit vack_e, hack_e, tick, dec, grant, promote, lock_e;
        int sel;
        logic [1:0]  exp_op;
        logic [21:0] exp_addr;
        logic [7:0]  exp_len;
        logic [15:0] exp_wdata;
        exp_op = 0; exp_addr = 0; exp_len = 0; exp_wdata = 0; sel = 0;
        #1;
        vack_e = (m_own == 2) && seq_done;
        hack_e = (m_own == 3) && seq_done;
        check("vid_ack", 32'(vid_ack), 32'(vack_e));
        check("host_ack", 32'(host_ack), 32'(hack_e));
        tick  = ((e % P) == P - 1);
        dec   = 0;
        grant = 0;
`ifdef SDRAM_ARB_HOST_PROMOTE_EN
        promote = (m_wait >= HMW);
`else
        promote = 0;
`endif
        if (m_own != 0) begin
            if (seq_done) begin
                if (m_own == 1) dec = 1;
                if (m_own == 3 && !m_we) m_rdata = seq_rdata;
                m_own = 0;
            end
        end else if (m_ready) begin
            if (m_pend >= URG) sel = 1;
            else if (promote && host_req) sel = 3;
            else if (vid_req) sel = 2;
            else if (m_pend > 0) sel = 1;
            else if (host_req) sel = 3;
            if (sel != 0) begin
                grant = 1;
                m_own = sel;
                m_we  = host_we;
                exp_op    = (sel == 1) ? 2'd0 : (sel == 2) ? 2'd1 : (host_we ? 2'd3 : 2'd2);
                exp_addr  = (sel == 2) ? vid_addr : host_addr;
                exp_len   = (sel == 2) ? 8'(VB) : 8'd1;
                exp_wdata = host_wdata;
            end
        end else if (seq_ready) begin
            m_ready = 1;
        end
        if (tick && !dec) begin
            if (m_pend < PMX) m_pend++;
        end else if (dec && !tick && m_pend > 0) begin
            m_pend--;
        end
        if (hack_e) m_wait = 0;
        else if (host_req && m_wait < HMW) m_wait++;
        e++;
        @(posedge clock);
        #1;
        lock_e = !m_ready || (m_own == 1) || (m_own == 2);
        check("seq_start", 32'(seq_start), 32'(grant));
        check("lock", 32'(lock), 32'(lock_e));
        check("host_rdata", 32'(host_rdata), 32'(m_rdata));
        if (grant) begin
            check("seq_op", 32'(seq_op), 32'(exp_op));
            if (sel != 1) begin
                check("seq_addr", 32'(seq_addr), 32'(exp_addr));
                check("seq_len", 32'(seq_len), 32'(exp_len));
            end
            if (exp_op == 2'd3) check("seq_wdata", 32'(seq_wdata), 32'(exp_wdata));
            if (sel == 3) host_grants++;
        end
        seq_done = 0;
        if (grant) begin
            done_cnt = cur_lat;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                seq_done  = 1;
                seq_rdata = 16'($urandom);
            end
        end else if (spur_en && m_own == 0 && $urandom_range(7) == 0) begin
            seq_done  = 1;
            seq_rdata = 16'($urandom);
        end
        if (hack_e) host_req = 0;
        if (vack_e && vid_oneshot) vid_req = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((host_req || vid_req || m_own != 0 || done_cnt != 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= max_cyc), 32'd0);
    endtask

    initial begin
        reset = 1; cur_lat = 3; spur_en = 0; vid_oneshot = 1; host_grants = 0;
        do_reset();

        // init: ready arrives at cycle 10, lock falls one cycle later
        repeat (10) step();
        seq_ready = 1;
        step();

        // host write from idle arbiter, sequencer takes 6 cycles
        host_req = 1; host_we = 1; host_addr = 22'h12345; host_wdata = 16'hBEEF;
        cur_lat = 6;
        wait_idle(50);

        // video and host together: burst first, then host read
        vid_req = 1; vid_addr = 22'h2A000;
        host_req = 1; host_we = 0; host_addr = 22'h00777;
        cur_lat = 4;
        wait_idle(100);

        // video grant held for 4 refresh periods -> refresh jumps ahead
        vid_oneshot = 0; vid_req = 1;
        cur_lat = 4 * P + 5;
        step();
        cur_lat = 3;
        repeat (4 * P + 80) step();
        vid_req = 0;
        wait_idle(500);

        // completion withheld for 10 periods -> pending saturates, then drains
        host_req = 1; host_we = 1; host_addr = 22'h3FFFFF; host_wdata = 16'h1234;
        cur_lat = 10 * P;
        step();
        cur_lat = 3;
        repeat (10 * P + 120) step();
        wait_idle(500);

        // randomized traffic with stray seq_done and one mid-operation reset
        spur_en = 1; vid_oneshot = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                do_reset();
                repeat (3) step();
                seq_ready = 1;
            end
            if (!host_req && $urandom_range(3) == 0) begin
                host_req   = 1;
                host_we    = 1'($urandom);
                host_addr  = 22'($urandom);
                host_wdata = 16'($urandom);
            end
            if ($urandom_range(3) == 0) vid_req = ~vid_req;
            vid_addr = 22'($urandom);
            cur_lat  = $urandom_range(1, 8);
            step();
        end
        spur_en = 0;
        vid_req = 0;
        wait_idle(2000);

        // starved host behind continuous video
        do_reset();
        seq_ready = 1;
        step();
        host_grants = 0;
        vid_oneshot = 0; vid_req = 1; vid_addr = 22'h100;
        host_req = 1; host_we = 1; host_addr = 22'h55; host_wdata = 16'hCAFE;
        cur_lat = 5;
        repeat (HMW + 300) step();
`ifdef SDRAM_ARB_HOST_PROMOTE_EN
        check("promote_grants", 32'(host_grants), 32'd1);
`else
        check("promote_grants", 32'(host_grants), 32'd0);
`endif
        vid_req = 0;
        wait_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Schedules all accesses to the single SDRAM device and shares it between three requesters: VGA line prefetch, periodic auto-refresh and a host word port.
- Sits between the requesters and the SDRAM command sequencer, which owns RAS/CAS/WE/addr/dq timing.
- Issues one operation at a time to the sequencer and returns acks and read data to the owning requester.

Parameters:
- REFRESH_PERIOD, 780, clock cycles between refresh ticks (7.8 µs at 100 MHz).
- REFRESH_URGENT, 4, pending-refresh count at which refresh preempts video.
- REFRESH_MAX, 8, saturation value of the pending-refresh counter.
- VID_BURST, 128, words per video burst (seq_len value).
- HOST_MAX_WAIT, 2048, cycles before a waiting host is promoted (optional feature only).

Ports:
- clock  in  1  100 MHz system clock
- reset  in  1  asynchronous active-high reset
- seq_ready  in  1  sequencer finished SDRAM init
- seq_start  out  1  one-cycle pulse: launch operation
- seq_op  out  2  0=REFRESH, 1=READ_BURST, 2=READ, 3=WRITE
- seq_addr  out  22  word address
- seq_len  out  8  burst length (1 for host ops)
- seq_wdata  out  16  host write data
- seq_rdata  in  16  host read data, valid with seq_done
- seq_done  in  1  one-cycle pulse: operation complete, bank precharged
- vid_req  in  1  level: video burst wanted
- vid_addr  in  22  burst start address
- vid_ack  out  1  one-cycle pulse: burst complete
- host_req  in  1  level, held until host_ack
- host_we  in  1  1=write
- host_addr  in  22  word address
- host_wdata  in  16  write data
- host_ack  out  1  one-cycle pulse
- host_rdata  out  16  read data, registered
- lock  out  1  1 = host request will not be served promptly (init, or video/refresh owns SDRAM)

Behaviour:
- Reset values: seq_start=0, seq_op=0, seq_addr=0, seq_len=0, seq_wdata=0, vid_ack=0, host_ack=0, host_rdata=0, lock=1, FSM=INIT, refresh timer=0, pending=0.
- Reset asserted mid-operation aborts ownership immediately; the sequencer is reset by the same signal.
- Refresh timer runs from reset; on reaching REFRESH_PERIOD-1 it wraps to 0 and pending increments, saturating at REFRESH_MAX.
- When a tick and a refresh completion coincide, pending stays unchanged.
- INIT: wait for seq_ready=1, then go to IDLE with lock=0.
- IDLE: the following priority selects one operation; seq_start pulses the next cycle with op/addr/len/wdata registered, FSM goes to BUSY:
  1. pending >= REFRESH_URGENT -> REFRESH
  2. vid_req -> READ_BURST, seq_len=VID_BURST
  3. pending > 0 -> REFRESH
  4. host_req -> READ or WRITE
- BUSY: hold all seq_* outputs stable; seq_start=0. On seq_done:
  - decrement pending (refresh op), or
  - pulse vid_ack (video op), or
  - pulse host_ack and latch seq_rdata into host_rdata on reads (host op).
  - Then return to IDLE.
- Back-to-back ops: earliest next seq_start is 2 cycles after seq_done.
- Host requesters sample host_ack only; host_rdata holds until the next host read completes.
- lock=1 in INIT, and in BUSY whenever the owner is not the host; otherwise 0.
- Host write latency from an idle arbiter: seq_start 1 cycle after host_req is seen in IDLE.
- seq_done while in IDLE or INIT: ignored.
- vid_req dropped during its own burst: ignored; the burst completes.

Optional Feature:
- Macro SDRAM_ARB_HOST_PROMOTE_EN.
- Defined: a wait counter runs while host_req=1 and no host_ack has occurred. Once it reaches HOST_MAX_WAIT, host is ranked above video but below urgent refresh. The counter clears on host_ack.
- Undefined: strict priority as listed above; no counter is synthesized.

Decomposition:
- Shared package sdram_pkg: seq_op encodings (OP_REFRESH, OP_READ_BURST, OP_READ, OP_WRITE), FSM state encodings (ST_INIT, ST_IDLE, ST_BUSY), and owner IDs.
- One sub-module, sdram_refresh_timer: period counter plus saturating pending counter, with inputs tick_dec/clear and outputs pending and urgent.

Test Plan:
- Reset, then seq_ready=1 at cycle 10 -> lock falls at cycle 11; no seq_start before then.
- Idle, host write addr=0x12345 data=0xBEEF -> seq_start 1 cycle later with op=3, len=1. Sequencer done after 6 cycles -> host_ack pulse in the same cycle as seq_done.
- vid_req and host_req asserted together, pending=0 -> READ_BURST len=128 first. Host READ follows, and host_rdata equals the seq_rdata returned.
- Hold the video grant continuously for 4×780 cycles -> pending reaches 4; the next IDLE issues REFRESH ahead of video; pending decrements on each seq_done.
- Suppress seq_done for 10×780 cycles -> pending saturates at 8, then drains to 0 over 8 REFRESH ops when idle.
- SDRAM_ARB_HOST_PROMOTE_EN defined, vid_req stuck high, host waiting -> after 2048 cycles the host op is granted before the next video burst. With the macro undefined, the host is never granted.
